// File: rtl/loader_pkg.sv
// Shared definitions for the pipeline front-end loader.
//   state_t           : FSM state encoding, also driven out on o_state
//   CMD_*             : command bytes recognised on the receive stream
//   HALT_WORD_DEFAULT : end-of-program marker word
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_NEXT = 8'h4E;  // 'N'

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into NBITS-wide words.
//   clk, rst   : clock, synchronous active-low reset
//   clear      : drop any partial word and restart at byte 0
//   shift_en   : rx_data is a payload byte this cycle
//   rx_data    : payload byte
//   word_done  : combinational strobe, this byte completes a word
//   word_next  : the word including this cycle's byte (full word when word_done)
// word_done/word_next are combinational so the caller can register the
// memory write on the very edge that accepts the last byte.
module word_assembler #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [7:0]       rx_data,
  output logic             word_done,
  output logic [NBITS-1:0] word_next
);

  localparam int NBYTES = NBITS / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  logic [CW-1:0]    byte_cnt;
  // Only the bytes received so far need storing; the newest byte arrives
  // on rx_data and lands in the top of word_next.
  logic [NBITS-9:0] shreg;

  assign word_next = {rx_data, shreg};
  assign word_done = shift_en && (byte_cnt == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (shift_en) begin
      shreg    <= word_next[NBITS-1:8];
      byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pipe_loader.sv
// Front-end controller for datapath_pipe: loads instruction memory from a
// UART byte stream, then holds / runs / single-steps the pipeline.
//   clk, rst     : clock, synchronous active-low reset
//   i_rx_data    : received byte, qualified by i_rx_valid (1-cycle strobe)
//   i_halt       : pipeline has retired a halt instruction (level)
//   o_imem_*     : instruction-memory write port (we, word address, data)
//   o_pipe_rst   : active-high pipeline reset (high in IDLE and LOAD)
//   o_pipe_en    : pipeline clock enable
//   o_load_done  : one-cycle pulse with the final write of a load
//   o_overflow   : sticky, program filled the memory without a halt word
//   o_state      : current FSM state (loader_pkg::state_t encoding)
// Every output is registered; a byte seen in cycle N acts in cycle N+1.
module pipe_loader
  import loader_pkg::*;
#(
  parameter int                MEM_SIZE  = 6,
  parameter int                NBITS     = 32,
  parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_halt,
  output logic                o_imem_we,
  output logic [MEM_SIZE-1:0] o_imem_addr,
  output logic [NBITS-1:0]    o_imem_data,
  output logic                o_pipe_rst,
  output logic                o_pipe_en,
  output logic                o_load_done,
  output logic                o_overflow,
  output logic [2:0]          o_state
);

  localparam logic [MEM_SIZE-1:0] LAST_ADDR = '1;

  state_t           state;
  logic             load_cmd;
  logic             shift_en;
  logic             word_done;
  logic [NBITS-1:0] word_next;

  // 'L' is honoured from IDLE and HALTED; it also restarts the assembler.
  assign load_cmd = i_rx_valid && (i_rx_data == CMD_LOAD) &&
                    ((state == ST_IDLE) || (state == ST_HALTED));
  assign shift_en = i_rx_valid && (state == ST_LOAD);
  assign o_state  = state;

  word_assembler #(.NBITS(NBITS)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (load_cmd),
    .shift_en  (shift_en),
    .rx_data   (i_rx_data),
    .word_done (word_done),
    .word_next (word_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      o_imem_we   <= 1'b0;
      o_imem_addr <= '0;
      o_imem_data <= '0;
      o_pipe_rst  <= 1'b1;
      o_pipe_en   <= 1'b0;
      o_load_done <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_imem_we   <= 1'b0;
      o_load_done <= 1'b0;
      o_pipe_en   <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_pipe_rst <= 1'b1;
          if (load_cmd) begin
            state       <= ST_LOAD;
            o_imem_addr <= '0;
            o_overflow  <= 1'b0;
          end else if (i_rx_valid && (i_rx_data == CMD_RUN)) begin
            state      <= ST_RUN;
            o_pipe_rst <= 1'b0;
            o_pipe_en  <= 1'b1;
          end else if (i_rx_valid && (i_rx_data == CMD_STEP)) begin
            state      <= ST_STEP;
            o_pipe_rst <= 1'b0;
          end
        end
        ST_LOAD: begin
          o_pipe_rst <= 1'b1;
          // Address moves on after the write cycle so it is stable while
          // o_imem_we is high. A terminating write leaves LOAD at the same
          // edge, so it never increments here.
          if (o_imem_we) o_imem_addr <= o_imem_addr + MEM_SIZE'(1);
          if (word_done) begin
            o_imem_we   <= 1'b1;
            o_imem_data <= word_next;
            if (word_next == HALT_WORD) begin
              o_load_done <= 1'b1;
              state       <= ST_IDLE;
            end else if (o_imem_addr == LAST_ADDR) begin
              o_overflow  <= 1'b1;
              o_load_done <= 1'b1;
              state       <= ST_IDLE;
            end
          end
        end
        ST_RUN: begin
          o_pipe_rst <= 1'b0;
          if (i_halt) state <= ST_HALTED;
          else        o_pipe_en <= 1'b1;
        end
        ST_STEP: begin
          o_pipe_rst <= 1'b0;
          // Halt has priority over any command arriving in the same cycle.
          if (i_halt) begin
            state <= ST_HALTED;
          end else if (i_rx_valid && (i_rx_data == CMD_RUN)) begin
            state     <= ST_RUN;
            o_pipe_en <= 1'b1;
          end else if (i_rx_valid && (i_rx_data == CMD_NEXT)) begin
            o_pipe_en <= 1'b1;
          end
        end
        ST_HALTED: begin
          o_pipe_rst <= 1'b0;
          if (load_cmd) begin
            state       <= ST_LOAD;
            o_pipe_rst  <= 1'b1;
            o_imem_addr <= '0;
            o_overflow  <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          o_pipe_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_loader.sv
// Bench for pipe_loader: command table, hand-written load/run/reset
// sequences and randomized loads/steps against a transaction-level model.
module tb_pipe_loader;
  import loader_pkg::*;

  localparam int          MEM_SIZE = 6;
  localparam int          NBITS    = 32;
  localparam logic [31:0] HW       = 32'hFFFF_FFFF;
  localparam int          NWORDS   = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]          rx_data  = 8'h00;
  logic                rx_valid = 1'b0;
  logic                halt     = 1'b0;
  logic                o_imem_we;
  logic [MEM_SIZE-1:0] o_imem_addr;
  logic [NBITS-1:0]    o_imem_data;
  logic                o_pipe_rst, o_pipe_en, o_load_done, o_overflow;
  logic [2:0]          o_state;

  pipe_loader #(.MEM_SIZE(MEM_SIZE), .NBITS(NBITS), .HALT_WORD(HW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .i_halt      (halt),
    .o_imem_we   (o_imem_we),
    .o_imem_addr (o_imem_addr),
    .o_imem_data (o_imem_data),
    .o_pipe_rst  (o_pipe_rst),
    .o_pipe_en   (o_pipe_en),
    .o_load_done (o_load_done),
    .o_overflow  (o_overflow),
    .o_state     (o_state)
  );

  // ---------------- scoreboard ----------------
  // Entry format {we, done, addr, data}.
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          en_cnt = 0;
  int          exp_addr = 0;

  // Monitor samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (o_pipe_en) en_cnt <= en_cnt + 1;
    if (o_imem_we || o_load_done)
      obs_q.push_back({o_imem_we, o_load_done, o_imem_addr, o_imem_data});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of a load: one write per word at consecutive
  // addresses; the load ends on the halt word or on the last address.
  task automatic model_word(input logic [31:0] w);
    logic done;
    done = (w == HW) || (exp_addr == NWORDS - 1);
    exp_q.push_back({1'b1, done, 6'(exp_addr), w});
    if (!done) exp_addr++;
  endtask

  task automatic drain(input string name);
    logic [39:0] o;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s_unexpected_write: got %0h expected none", name, o);
      end else begin
        check({name, "_write"}, 64'(o), 64'(exp_q.pop_front()));
      end
    end
    check({name, "_missing_writes"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- driver tasks (all return at posedge+1) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  task automatic do_reset(input string name);
    rst      = 1'b0;
    rx_valid = 1'b0;
    halt     = 1'b0;
    tick();
    check({name, "_state"},   64'(o_state),     64'd0);
    check({name, "_we"},      64'(o_imem_we),   64'd0);
    check({name, "_addr"},    64'(o_imem_addr), 64'd0);
    check({name, "_data"},    64'(o_imem_data), 64'd0);
    check({name, "_pipe_rst"},64'(o_pipe_rst),  64'd1);
    check({name, "_pipe_en"}, 64'(o_pipe_en),   64'd0);
    check({name, "_done"},    64'(o_load_done), 64'd0);
    check({name, "_ovf"},     64'(o_overflow),  64'd0);
    tick();
    rst = 1'b1;
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- command table ----------------
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       h;
    logic [2:0] st;
    logic       en;
    logic       prst;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic h,
                              input logic [2:0] st, input logic en, input logic prst);
    vec_t r;
    r.v = v; r.d = d; r.h = h; r.st = st; r.en = en; r.prst = prst;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    int base, k;
    logic [31:0] w;

    // Inputs, then state/enable/pipe-reset expected after the edge.
    tbl.push_back(mk(0, 8'h00, 0, 3'd0, 0, 1));
    tbl.push_back(mk(1, 8'h41, 0, 3'd0, 0, 1));  // unknown byte ignored
    tbl.push_back(mk(1, 8'h53, 0, 3'd3, 0, 0));  // S
    tbl.push_back(mk(0, 8'h00, 0, 3'd3, 0, 0));
    tbl.push_back(mk(1, 8'h4E, 0, 3'd3, 1, 0));  // N
    tbl.push_back(mk(0, 8'h00, 0, 3'd3, 0, 0));
    tbl.push_back(mk(1, 8'h4E, 0, 3'd3, 1, 0));  // N N back to back
    tbl.push_back(mk(1, 8'h4E, 0, 3'd3, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 3'd3, 0, 0));
    tbl.push_back(mk(1, 8'h4E, 1, 3'd4, 0, 0));  // N with halt: halt wins
    tbl.push_back(mk(1, 8'h52, 0, 3'd4, 0, 0));  // R ignored in HALTED
    tbl.push_back(mk(1, 8'h53, 0, 3'd4, 0, 0));  // S ignored
    tbl.push_back(mk(1, 8'h4E, 0, 3'd4, 0, 0));  // N ignored
    tbl.push_back(mk(1, 8'h4C, 0, 3'd1, 0, 1));  // L from HALTED
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 8'hFF, 0, 3'd1, 0, 1));
    tbl.push_back(mk(1, 8'hFF, 0, 3'd0, 0, 1));  // halt word ends load
    tbl.push_back(mk(1, 8'h52, 0, 3'd2, 1, 0));  // R
    tbl.push_back(mk(0, 8'h00, 0, 3'd2, 1, 0));
    tbl.push_back(mk(1, 8'h53, 0, 3'd2, 1, 0));  // S ignored in RUN
    tbl.push_back(mk(1, 8'h4E, 0, 3'd2, 1, 0));  // N ignored in RUN
    tbl.push_back(mk(1, 8'h4C, 0, 3'd2, 1, 0));  // L ignored in RUN
    tbl.push_back(mk(0, 8'h00, 1, 3'd4, 0, 0));  // halt
    tbl.push_back(mk(0, 8'h00, 0, 3'd4, 0, 0));
    tbl.push_back(mk(1, 8'h4C, 0, 3'd1, 0, 1));  // L again
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 8'hFF, 0, 3'd1, 0, 1));
    tbl.push_back(mk(1, 8'hFF, 0, 3'd0, 0, 1));
    tbl.push_back(mk(1, 8'h53, 0, 3'd3, 0, 0));  // S
    tbl.push_back(mk(1, 8'h52, 0, 3'd2, 1, 0));  // R from STEP
    tbl.push_back(mk(0, 8'h00, 1, 3'd4, 0, 0));

    // ---- initial reset ----
    do_reset("reset");

    // ---- table ----
    exp_addr = 0; model_word(HW);
    exp_addr = 0; model_word(HW);
    foreach (tbl[i]) begin
      rx_valid = tbl[i].v;
      rx_data  = tbl[i].d;
      halt     = tbl[i].h;
      tick();
      check($sformatf("tbl%0d_state", i), 64'(o_state),    64'(tbl[i].st));
      check($sformatf("tbl%0d_en", i),    64'(o_pipe_en),  64'(tbl[i].en));
      check($sformatf("tbl%0d_prst", i),  64'(o_pipe_rst), 64'(tbl[i].prst));
    end
    rx_valid = 1'b0;
    halt     = 1'b0;
    tick();
    drain("tbl");

    // ---- basic two-word load with latency checks ----
    do_reset("rst_a");
    send_byte(CMD_LOAD);
    check("a_state_load", 64'(o_state), 64'd1);
    exp_addr = 0;
    model_word(32'h2001_0013);
    model_word(HW);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h01); send_byte(8'h20);
    check("a_we_latency", 64'(o_imem_we),   64'd1);
    check("a_addr0",      64'(o_imem_addr), 64'd0);
    check("a_data0",      64'(o_imem_data), 64'h2001_0013);
    tick();
    check("a_we_one_cycle", 64'(o_imem_we),   64'd0);
    check("a_addr_incr",    64'(o_imem_addr), 64'd1);
    repeat (4) send_byte(8'hFF);
    check("a_done_pulse", 64'(o_load_done), 64'd1);
    check("a_state_idle", 64'(o_state),     64'd0);
    tick();
    check("a_done_clear", 64'(o_load_done), 64'd0);
    check("a_pipe_rst",   64'(o_pipe_rst),  64'd1);
    drain("a");

    // ---- run then halt ----
    send_byte(CMD_RUN);
    check("b_pipe_rst", 64'(o_pipe_rst), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("b_run_en", 64'(o_pipe_en), 64'd1);
      tick();
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("b_halt_en",    64'(o_pipe_en), 64'd0);
    check("b_halt_state", 64'(o_state),   64'd4);

    // ---- overflow: 64 non-halt words ----
    do_reset("rst_c");
    send_byte(CMD_LOAD);
    exp_addr = 0;
    for (int i = 0; i < NWORDS; i++) begin
      w = $urandom();
      if (w == HW) w = 32'h0;
      model_word(w);
      send_word(w, 0);
    end
    check("c_overflow", 64'(o_overflow), 64'd1);
    check("c_state",    64'(o_state),    64'd0);
    repeat (4) tick();
    check("c_addr_hold", 64'(o_imem_addr), 64'd63);
    drain("c");
    send_byte(CMD_LOAD);
    check("c_ovf_cleared", 64'(o_overflow), 64'd0);

    // ---- reset in the middle of a word ----
    send_byte(8'hAA); send_byte(8'hBB);
    do_reset("rst_mid");
    tick();
    check("d_no_write", 64'(obs_q.size()), 64'd0);
    send_byte(CMD_LOAD);
    exp_addr = 0;
    model_word(32'h4433_2211);
    send_word(32'h4433_2211, 0);
    tick();
    drain("d");

    // ---- randomized loads and steps ----
    for (int it = 0; it < 8; it++) begin
      do_reset("rst_r");
      send_byte(CMD_LOAD);
      exp_addr = 0;
      k = $urandom_range(1, 10);
      for (int i = 0; i < k; i++) begin
        w = $urandom();
        if (w == HW) w = 32'h1;
        model_word(w);
        send_word(w, 2);
      end
      model_word(HW);
      send_word(HW, 2);
      check("r_state_idle", 64'(o_state), 64'd0);
      tick();
      drain("r");
      send_byte(CMD_STEP);
      base = en_cnt;
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) begin
        send_byte(CMD_NEXT);
        repeat ($urandom_range(0, 3)) tick();
      end
      tick();
      check("r_step_pulses", 64'(en_cnt - base), 64'(k));
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check("r_halted", 64'(o_state), 64'd4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_loader.md
# pipe_loader

Front-end controller sitting directly upstream of `datapath_pipe`. It receives a byte stream from the UART receiver, assembles little-endian 32-bit instruction words and writes them into the pipeline's instruction memory. It then holds, releases, free-runs or single-steps the pipeline under command-byte control until the pipeline reports a halt.

## Interface

Parameters:
- `MEM_SIZE`, 6: instruction-memory word-address width (64 words).
- `NBITS`, 32: instruction width.
- `HALT_WORD`, 32'hFFFF_FFFF: end-of-program marker.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `i_rx_data` in 8: received byte.
- `i_rx_valid` in 1: one-cycle strobe; `i_rx_data` is valid this cycle.
- `i_halt` in 1: pipeline has retired a halt instruction (level).
- `o_imem_we` in/out direction out, 1: instruction-memory write enable.
- `o_imem_addr` out `MEM_SIZE`: instruction-memory word address.
- `o_imem_data` out `NBITS`: instruction-memory write data.
- `o_pipe_rst` out 1: active-high reset to `datapath_pipe`.
- `o_pipe_en` out 1: pipeline clock enable (stall when 0).
- `o_load_done` out 1: one-cycle pulse when a load ends.
- `o_overflow` out 1: sticky; the program did not fit in memory.
- `o_state` out 3: current state encoding, for debug.

## Operation

- States: IDLE=0, LOAD=1, RUN=2, STEP=3, HALTED=4. Command bytes are 'L'=8'h4C, 'R'=8'h52, 'S'=8'h53, 'N'=8'h4E.
- IDLE:
  - 'L' → LOAD. Clear the address, byte counter and `o_overflow`.
  - 'R' → RUN.
  - 'S' → STEP.
  - Any other byte is ignored.
- LOAD: every valid byte is shifted into the word register, little-endian (first byte is bits [7:0]).
  - On the 4th byte, issue one write at the current address and clear the byte counter.
  - If the word equals `HALT_WORD`: the write still happens, then pulse `o_load_done` → IDLE.
  - Otherwise increment the address. If the write used the last address (2^MEM_SIZE−1), set `o_overflow`, pulse `o_load_done` → IDLE. The address does not wrap.
- RUN: `o_pipe_en`=1 every cycle. Command bytes are ignored. `i_halt`=1 → HALTED.
- STEP:
  - 'N' gives `o_pipe_en`=1 for exactly one cycle.
  - 'R' → RUN.
  - `i_halt`=1 → HALTED. Halt wins over a simultaneous 'N'.
- HALTED: `o_pipe_en`=0 and `o_pipe_rst`=0, so pipeline state is kept for inspection.
  - 'L' → LOAD.
  - 'R' and 'S' are ignored until the next load.
- `o_pipe_rst`=1 in IDLE and LOAD, and 0 in RUN, STEP and HALTED.

## Timing

- Reset values (while `rst`=0): state IDLE, `o_imem_we`=0, `o_imem_addr`=0, `o_imem_data`=0, `o_pipe_rst`=1, `o_pipe_en`=0, `o_load_done`=0, `o_overflow`=0, byte counter 0.
- All outputs are registered.
- A byte accepted at edge N takes effect in state/outputs after edge N+1.
- Write latency: 4th byte accepted in cycle N → `o_imem_we`=1 with stable address and data in cycle N+1, for one cycle.
  - The address increments after the write edge.
  - `o_load_done` goes high in the same cycle as the `HALT_WORD` write.
- 'N' in cycle N → `o_pipe_en`=1 in cycle N+1 only.
- Back-to-back 'N' bytes give one enable pulse each.
- `i_halt` sampled in cycle N → `o_pipe_en`=0 from cycle N+1. At most one extra enable cycle after halt retire is not allowed.
- `i_rx_valid` on consecutive cycles must be accepted with no byte dropped.
- Reset mid-LOAD drops the partial word and any pending write (no `o_imem_we` after reset).

## Structure

- Shared package `loader_pkg`: state encodings, command-byte constants, `HALT_WORD` default.
- One sub-module: `word_assembler` (byte counter, shift register, word-complete strobe).
- The FSM and address counter stay in `pipe_loader`.

## Test plan

- Reset, then 'L' followed by bytes 13,00,01,20 and FF×4 → write 32'h2001_0013 at address 0, then 32'hFFFF_FFFF at address 1 with `o_load_done` pulse. State returns to IDLE and `o_pipe_rst`=1.
- After a load, 'R' → `o_pipe_rst`=0 and `o_pipe_en`=1 continuously. Raise `i_halt` → `o_pipe_en`=0 next cycle and state HALTED (4).
- 'S' then three 'N' bytes 5 cycles apart → exactly three single-cycle `o_pipe_en` pulses. 'N' coincident with `i_halt` → no pulse, HALTED.
- Load 64 non-halt words → last write at address 63, `o_overflow`=1, `o_load_done` pulse, no write to address 0 afterwards.
- Assert `rst`=0 after 2 bytes of a word → all outputs at reset values. A new 'L' plus 4 bytes writes the full new word at address 0.
- In RUN and HALTED, send 'S'/'R'/'N' → no state change and no enable pulse. In HALTED, 'L' → LOAD with `o_pipe_rst`=1.
